// File: rtl/seg_timer_sched_pkg.sv
// Shared definitions for the seconds scheduler: channel state encoding,
// board clock rate and the constant clog2 used to size the prescaler.
package seg_timer_sched_pkg;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    localparam int CLK_HZ          = 50000000;
    localparam int TICK_CYCLES_DEF = CLK_HZ;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seg_timer_sched_tick_gen.sv
// Free-running prescaler producing the shared one-cycle tick and the
// SEGUNDO square wave that flips together with every tick.
module tick_gen
    import seg_timer_sched_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic mclk,
    input  logic reset,
    output logic tick,
    output logic segundo
);

    // A one-cycle timebase still needs a one-bit counter to stay legal.
    localparam int            CW   = (clog2(TICK_CYCLES) < 1) ? 1 : clog2(TICK_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          tick_reg;
    logic          tick_next;
    logic          segundo_reg;
    logic          segundo_next;
    logic          wrap;

    assign wrap = (count_reg == LAST);

    always_comb begin
        count_next   = wrap ? '0 : count_reg + 1'b1;
        tick_next    = wrap;
        segundo_next = segundo_reg ^ wrap;
    end

    always_ff @(posedge mclk) begin
        if (!reset) begin
            count_reg   <= '0;
            tick_reg    <= 1'b0;
            segundo_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            tick_reg    <= tick_next;
            segundo_reg <= segundo_next;
        end
    end

    assign tick    = tick_reg;
    assign segundo = segundo_reg;

endmodule

// File: rtl/seg_timer_sched.sv
// Multi-channel seconds scheduler: NCH independent countdown channels all
// clocked by one shared tick from the prescaler.
module seg_timer_sched
    import seg_timer_sched_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_CYCLES_DEF,
    parameter int NCH         = 4,
    parameter int PW          = 8
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic [NCH-1:0]    start,
    input  logic [NCH-1:0]    stop,
    input  logic [NCH*PW-1:0] period,
    output logic              tick,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done,
    output logic              SEGUNDO
);

    logic tick_w;

    tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .mclk    (mclk),
        .reset   (reset),
        .tick    (tick_w),
        .segundo (SEGUNDO)
    );

    assign tick = tick_w;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        ch_state_t      state_reg;
        ch_state_t      state_next;
        logic [PW-1:0]  remaining_reg;
        logic [PW-1:0]  remaining_next;
        logic           done_reg;
        logic           done_next;
        logic           busy_out;
        logic [PW-1:0]  load_val;

        assign load_val = period[gi*PW +: PW];

        always_ff @(posedge mclk) begin
            if (!reset) begin
                state_reg     <= CH_IDLE;
                remaining_reg <= '0;
                done_reg      <= 1'b0;
            end else begin
                state_reg     <= state_next;
                remaining_reg <= remaining_next;
                done_reg      <= done_next;
            end
        end

        // Priority in RUN: stop, then retrigger, then the tick.
        always_comb begin
            state_next     = state_reg;
            remaining_next = remaining_reg;
            done_next      = 1'b0;
            case (state_reg)
                CH_IDLE: begin
                    if (start[gi] && !stop[gi]) begin
                        if (load_val != '0) begin
                            state_next     = CH_RUN;
                            remaining_next = load_val;
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end
                CH_RUN: begin
                    if (stop[gi]) begin
                        state_next     = CH_IDLE;
                        remaining_next = '0;
                    end else if (start[gi]) begin
                        if (load_val == '0) begin
                            state_next     = CH_IDLE;
                            remaining_next = '0;
                            done_next      = 1'b1;
                        end else begin
                            remaining_next = load_val;
                        end
                    end else if (tick_w) begin
                        if (remaining_reg <= PW'(1)) begin
                            state_next     = CH_IDLE;
                            remaining_next = '0;
                            done_next      = 1'b1;
                        end else begin
                            remaining_next = remaining_reg - 1'b1;
                        end
                    end
                end
                default: begin
                    state_next     = CH_IDLE;
                    remaining_next = '0;
                end
            endcase
        end

        always_comb begin
            busy_out = (state_reg == CH_RUN);
        end

        assign busy[gi] = busy_out;
        assign done[gi] = done_reg;
    end

endmodule

// File: tb/tb_seg_timer_sched.sv
// Directed bench for seg_timer_sched with a 10-cycle timebase and four channels.
module tb_seg_timer_sched;

    localparam int TICK_CYCLES = 10;
    localparam int NCH         = 4;
    localparam int PW          = 8;

    logic              mclk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    start;
    logic [NCH-1:0]    stop;
    logic [NCH*PW-1:0] period;
    logic              tick;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;
    logic              SEGUNDO;

    int                vectors     = 0;
    int                miscompares = 0;
    logic [NCH-1:0]    done_acc    = '0;
    int                n;

    always #5 mclk = ~mclk;

    seg_timer_sched #(
        .TICK_CYCLES (TICK_CYCLES),
        .NCH         (NCH),
        .PW          (PW)
    ) dut (
        .mclk    (mclk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .period  (period),
        .tick    (tick),
        .busy    (busy),
        .done    (done),
        .SEGUNDO (SEGUNDO)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full clock cycle; outputs are then read at the falling edge.
    task automatic step();
        @(negedge mclk);
        done_acc = done_acc | done;
    endtask

    task automatic wait_tick(output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while (tick !== 1'b1 && steps < 40);
        check("tick_seen", {31'd0, tick}, 32'd1);
    endtask

    initial begin
        reset  = 1'b0;
        start  = 4'hF;
        stop   = 4'h0;
        period = 32'h0303_0303;
        step();
        step();
        step();
        check("rst_busy", {28'd0, busy}, 32'd0);
        check("rst_done", {28'd0, done}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_segundo", {31'd0, SEGUNDO}, 32'd0);

        // Release: tick spacing and SEGUNDO toggling.
        reset = 1'b1;
        start = 4'h0;
        wait_tick(n);
        check("first_tick_delay", n, 32'd10);
        check("segundo_after_tick1", {31'd0, SEGUNDO}, 32'd1);
        wait_tick(n);
        check("second_tick_delay", n, 32'd10);
        check("segundo_after_tick2", {31'd0, SEGUNDO}, 32'd0);
        $display("reset/timebase: tick spacing %0d", n);

        // Basic ch0, period 3, started in the tick cycle.
        period[7:0] = 8'd3;
        start[0]    = 1'b1;
        step();
        start[0] = 1'b0;
        n = 1;
        check("ch0_busy_start", {31'd0, busy[0]}, 32'd1);
        while (done[0] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("ch0_latency", n, 32'd31);
        check("ch0_busy_at_done", {31'd0, busy[0]}, 32'd0);
        step();
        check("ch0_done_single", {31'd0, done[0]}, 32'd0);
        $display("basic ch0: done after %0d cycles", n);

        // Zero period on ch1.
        period[15:8] = 8'd0;
        start[1]     = 1'b1;
        step();
        start[1] = 1'b0;
        check("ch1_zero_done", {31'd0, done[1]}, 32'd1);
        check("ch1_zero_busy", {31'd0, busy[1]}, 32'd0);
        step();
        check("ch1_zero_done_gone", {31'd0, done[1]}, 32'd0);
        check("ch1_zero_busy_after", {31'd0, busy[1]}, 32'd0);
        $display("zero period ch1: done=%0b busy=%0b", done[1], busy[1]);

        // Stop ch2 after two ticks.
        wait_tick(n);
        period[23:16] = 8'd5;
        start[2]      = 1'b1;
        step();
        start[2] = 1'b0;
        check("ch2_busy_start", {31'd0, busy[2]}, 32'd1);
        wait_tick(n);
        wait_tick(n);
        done_acc = '0;
        stop[2]  = 1'b1;
        step();
        stop[2] = 1'b0;
        check("ch2_stop_busy", {31'd0, busy[2]}, 32'd0);
        for (int i = 0; i < 60; i++) step();
        check("ch2_no_done", {31'd0, done_acc[2]}, 32'd0);
        start[2] = 1'b1;
        stop[2]  = 1'b1;
        step();
        start[2] = 1'b0;
        stop[2]  = 1'b0;
        check("ch2_startstop_busy", {31'd0, busy[2]}, 32'd0);
        check("ch2_startstop_done", {31'd0, done[2]}, 32'd0);
        step();
        check("ch2_startstop_idle", {31'd0, busy[2]}, 32'd0);
        $display("stop ch2: busy=%0b done_seen=%0b", busy[2], done_acc[2]);

        // Retrigger ch3 on the tick that would expire it.
        wait_tick(n);
        period[31:24] = 8'd2;
        start[3]      = 1'b1;
        step();
        start[3] = 1'b0;
        check("ch3_busy_start", {31'd0, busy[3]}, 32'd1);
        wait_tick(n);
        wait_tick(n);
        start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        check("ch3_retrig_no_done", {31'd0, done[3]}, 32'd0);
        check("ch3_retrig_busy", {31'd0, busy[3]}, 32'd1);
        done_acc = '0;
        wait_tick(n);
        wait_tick(n);
        check("ch3_no_early_done", {31'd0, done_acc[3]}, 32'd0);
        step();
        check("ch3_done_after_2", {28'd0, done}, 32'h8);
        check("ch3_busy_cleared", {31'd0, busy[3]}, 32'd0);
        $display("retrigger ch3: done=%0h", done);

        // All channels together, period 4.
        wait_tick(n);
        period = 32'h0404_0404;
        start  = 4'hF;
        step();
        start = 4'h0;
        check("all_busy", {28'd0, busy}, 32'hF);
        done_acc = '0;
        for (int i = 0; i < 4; i++) wait_tick(n);
        check("all_no_early_done", {28'd0, done_acc}, 32'd0);
        step();
        check("all_done_together", {28'd0, done}, 32'hF);
        check("all_idle", {28'd0, busy}, 32'd0);
        step();
        check("all_done_pulse", {28'd0, done}, 32'd0);
        $display("concurrency: all channels expired together");

        // Mid-run reset.
        start = 4'hF;
        step();
        start = 4'h0;
        check("midrun_busy", {28'd0, busy}, 32'hF);
        for (int i = 0; i < 15; i++) step();
        done_acc = '0;
        reset    = 1'b0;
        step();
        check("midrun_rst_busy", {28'd0, busy}, 32'd0);
        check("midrun_rst_done", {28'd0, done}, 32'd0);
        check("midrun_rst_tick", {31'd0, tick}, 32'd0);
        check("midrun_rst_segundo", {31'd0, SEGUNDO}, 32'd0);
        step();
        step();
        check("midrun_no_done", {28'd0, done_acc}, 32'd0);
        reset = 1'b1;
        wait_tick(n);
        check("midrun_first_tick", n, 32'd10);
        $display("mid-run reset: busy=%0h first tick after %0d", busy, n);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
